// File: rtl/imp_interval_monitor_if.sv
// Pulse-former to interval-monitor bundle: shaped pulses, error clear and published results.
// With IMP_MON_MINMAX_EN defined the bundle also carries the tizl_min/tizl_max statistics.
interface imp_interval_monitor_if;
    logic        TNI_o;
    logic        TKI_o;
    logic        TNP_o;
    logic        TKP_o;
    logic        TNC_f;
    logic        err_clr;
    logic [31:0] meas_tizl;
    logic [31:0] meas_gap;
    logic [31:0] meas_tpr;
    logic [15:0] n_imp;
    logic        meas_valid;
    logic [1:0]  state_o;
    logic [7:0]  err;
`ifdef IMP_MON_MINMAX_EN
    logic [31:0] tizl_min;
    logic [31:0] tizl_max;

    modport master (
        output TNI_o, TKI_o, TNP_o, TKP_o, TNC_f, err_clr,
        input  meas_tizl, meas_gap, meas_tpr, n_imp, meas_valid, state_o, err,
        input  tizl_min, tizl_max
    );
    modport slave (
        input  TNI_o, TKI_o, TNP_o, TKP_o, TNC_f, err_clr,
        output meas_tizl, meas_gap, meas_tpr, n_imp, meas_valid, state_o, err,
        output tizl_min, tizl_max
    );
`else
    modport master (
        output TNI_o, TKI_o, TNP_o, TKP_o, TNC_f, err_clr,
        input  meas_tizl, meas_gap, meas_tpr, n_imp, meas_valid, state_o, err
    );
    modport slave (
        input  TNI_o, TKI_o, TNP_o, TKP_o, TNC_f, err_clr,
        output meas_tizl, meas_gap, meas_tpr, n_imp, meas_valid, state_o, err
    );
`endif
endinterface

// File: rtl/imp_interval_monitor.sv
// Measures TNI->TKI, TKI->TNP, TNP->TKP in 1 us ticks and publishes one result set per TNC cycle; no backpressure.
// Pulse edges act 2 clk after the input rises, results appear 1 clk after the TNC edge; IMP_MON_MINMAX_EN adds tizl_min/tizl_max.
module imp_interval_monitor #(
    parameter int unsigned MAX_CYCLE_US = 1000000,
    parameter int unsigned SYNC_STAGES  = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    T1us,
    imp_interval_monitor_if.slave   mon
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2,
        RECV = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   t1_prev_q;
    logic                   tick;

    logic [4:0] pin_q, pin_prev_q, edg;
    logic       e_tni, e_tki, e_tnp, e_tkp, e_tnc;

    state_t      state_q, state_d;
    logic [31:0] ivl_q, ivl_d;
    logic [31:0] wd_q, wd_d;
    logic [15:0] n_cnt_q, n_cnt_d;
    logic [31:0] tizl_hold_q, tizl_hold_d;
    logic [31:0] gap_hold_q, gap_hold_d;
    logic [31:0] tpr_hold_q, tpr_hold_d;
    logic [31:0] meas_tizl_q, meas_gap_q, meas_tpr_q;
    logic [15:0] n_imp_q;
    logic        meas_valid_q;
    logic        cycle_seen_q;
    logic [6:0]  err_q, err_d, err_set;
    logic        enter, lat_tizl, lat_gap, lat_tpr;
`ifdef IMP_MON_MINMAX_EN
    logic [31:0] tizl_min_q, tizl_min_d, tizl_max_q, tizl_max_d;
    logic [31:0] min_base, max_base;
`endif

    assign tick = sync_q[SYNC_STAGES-1] & ~t1_prev_q;

    // bit order {TNC, TKP, TNP, TKI, TNI}
    assign edg   = pin_q & ~pin_prev_q;
    assign e_tni = edg[0];
    assign e_tki = edg[1];
    assign e_tnp = edg[2];
    assign e_tkp = edg[3];
    assign e_tnc = edg[4];

    always_comb begin
        state_d  = state_q;
        enter    = 1'b0;
        lat_tizl = 1'b0;
        lat_gap  = 1'b0;
        lat_tpr  = 1'b0;
        err_set  = 7'd0;

        // TNI is checked first in every state, so a start edge always beats an end edge
        case (state_q)
            IDLE: begin
                if (e_tni) begin
                    state_d = EMIT; enter = 1'b1;
                end else if (e_tnp) begin
                    state_d = RECV; enter = 1'b1;
                end
            end
            EMIT: begin
                if (e_tni) begin
                    err_set[1] = 1'b1; enter = 1'b1;
                end else if (e_tki) begin
                    state_d = GAP; enter = 1'b1; lat_tizl = 1'b1;
                end
            end
            GAP: begin
                if (e_tni) begin
                    state_d = EMIT; enter = 1'b1;
                end else if (e_tnp) begin
                    state_d = RECV; enter = 1'b1; lat_gap = 1'b1;
                end
            end
            RECV: begin
                if (e_tni) begin
                    err_set[0] = 1'b1; state_d = EMIT; enter = 1'b1;
                end else if (e_tkp) begin
                    state_d = IDLE; enter = 1'b1; lat_tpr = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (e_tki && !lat_tizl) err_set[2] = 1'b1;
        if (e_tkp && !lat_tpr)  err_set[3] = 1'b1;

        ivl_d = ivl_q;
        if (enter) begin
            ivl_d = 32'd0;
        end else if (tick) begin
            if (ivl_q != 32'hFFFF_FFFF) ivl_d = ivl_q + 32'd1;
            if (ivl_q >= 32'hFFFF_FFFE) err_set[4] = 1'b1;
        end

        wd_d = wd_q;
        if (e_tnc) begin
            wd_d = 32'd0;
        end else if (tick) begin
            if (wd_q != 32'hFFFF_FFFF) wd_d = wd_q + 32'd1;
            if (wd_q == 32'(MAX_CYCLE_US - 1)) err_set[5] = 1'b1;
        end

        // TNC clears first; this clk's pulse edges then land in the new cycle
        n_cnt_d     = e_tnc ? 16'd0 : n_cnt_q;
        tizl_hold_d = e_tnc ? 32'd0 : tizl_hold_q;
        gap_hold_d  = e_tnc ? 32'd0 : gap_hold_q;
        tpr_hold_d  = e_tnc ? 32'd0 : tpr_hold_q;
        if (e_tni && n_cnt_d != 16'hFFFF) n_cnt_d = n_cnt_d + 16'd1;
        if (lat_tizl) tizl_hold_d = ivl_q;
        if (lat_gap)  gap_hold_d  = ivl_q;
        if (lat_tpr)  tpr_hold_d  = ivl_q;

        if (e_tnc && cycle_seen_q && n_cnt_q == 16'd0) err_set[6] = 1'b1;

        err_d = (mon.err_clr ? 7'd0 : err_q) | err_set;

`ifdef IMP_MON_MINMAX_EN
        min_base   = mon.err_clr ? 32'hFFFF_FFFF : tizl_min_q;
        max_base   = mon.err_clr ? 32'd0 : tizl_max_q;
        tizl_min_d = (lat_tizl && ivl_q < min_base) ? ivl_q : min_base;
        tizl_max_d = (lat_tizl && ivl_q > max_base) ? ivl_q : max_base;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            t1_prev_q    <= 1'b0;
            pin_q        <= 5'd0;
            pin_prev_q   <= 5'd0;
            state_q      <= IDLE;
            ivl_q        <= 32'd0;
            wd_q         <= 32'd0;
            n_cnt_q      <= 16'd0;
            tizl_hold_q  <= 32'd0;
            gap_hold_q   <= 32'd0;
            tpr_hold_q   <= 32'd0;
            meas_tizl_q  <= 32'd0;
            meas_gap_q   <= 32'd0;
            meas_tpr_q   <= 32'd0;
            n_imp_q      <= 16'd0;
            meas_valid_q <= 1'b0;
            cycle_seen_q <= 1'b0;
            err_q        <= 7'd0;
`ifdef IMP_MON_MINMAX_EN
            tizl_min_q   <= 32'hFFFF_FFFF;
            tizl_max_q   <= 32'd0;
`endif
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], T1us};
            t1_prev_q    <= sync_q[SYNC_STAGES-1];
            pin_q        <= {mon.TNC_f, mon.TKP_o, mon.TNP_o, mon.TKI_o, mon.TNI_o};
            pin_prev_q   <= pin_q;
            state_q      <= state_d;
            ivl_q        <= ivl_d;
            wd_q         <= wd_d;
            n_cnt_q      <= n_cnt_d;
            tizl_hold_q  <= tizl_hold_d;
            gap_hold_q   <= gap_hold_d;
            tpr_hold_q   <= tpr_hold_d;
            meas_valid_q <= e_tnc;
            if (e_tnc) begin
                meas_tizl_q  <= tizl_hold_q;
                meas_gap_q   <= gap_hold_q;
                meas_tpr_q   <= tpr_hold_q;
                n_imp_q      <= n_cnt_q;
                cycle_seen_q <= 1'b1;
            end
            err_q        <= err_d;
`ifdef IMP_MON_MINMAX_EN
            tizl_min_q   <= tizl_min_d;
            tizl_max_q   <= tizl_max_d;
`endif
        end
    end

    assign mon.meas_tizl  = meas_tizl_q;
    assign mon.meas_gap   = meas_gap_q;
    assign mon.meas_tpr   = meas_tpr_q;
    assign mon.n_imp      = n_imp_q;
    assign mon.meas_valid = meas_valid_q;
    assign mon.state_o    = state_q;
    assign mon.err        = {|err_q[5:0], err_q};
`ifdef IMP_MON_MINMAX_EN
    assign mon.tizl_min   = tizl_min_q;
    assign mon.tizl_max   = tizl_max_q;
`endif

endmodule

// File: tb/tb_imp_interval_monitor.sv
// Directed bench for imp_interval_monitor with hand-computed expectations; watchdog shortened to 200 us.
module tb_imp_interval_monitor;

    localparam logic [4:0] P_TNI = 5'b00001;
    localparam logic [4:0] P_TKI = 5'b00010;
    localparam logic [4:0] P_TNP = 5'b00100;
    localparam logic [4:0] P_TKP = 5'b01000;
    localparam logic [4:0] P_TNC = 5'b10000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic T1us  = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   vcnt  = 0;

    imp_interval_monitor_if mon ();

    imp_interval_monitor #(
        .MAX_CYCLE_US (200),
        .SYNC_STAGES  (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .T1us  (T1us),
        .mon   (mon)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one tick = T1us high 4 clk then low 4 clk, long enough for the synchroniser
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            T1us = 1'b1;
            repeat (4) @(negedge clk);
            T1us = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    // mask order {TNC, TKP, TNP, TKI, TNI}; counts meas_valid clocks seen while it settles
    task automatic pulse(input logic [4:0] m);
        vcnt = 0;
        {mon.TNC_f, mon.TKP_o, mon.TNP_o, mon.TKI_o, mon.TNI_o} = m;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 1) {mon.TNC_f, mon.TKP_o, mon.TNP_o, mon.TKI_o, mon.TNI_o} = 5'b0;
            if (mon.meas_valid) vcnt++;
        end
    endtask

    task automatic clear_err();
        mon.err_clr = 1'b1;
        @(negedge clk);
        mon.err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        {mon.TNC_f, mon.TKP_o, mon.TNP_o, mon.TKI_o, mon.TNI_o} = 5'b0;
        mon.err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tizl",  mon.meas_tizl, 32'd0);
        check("rst_n_imp", 32'(mon.n_imp), 32'd0);
        check("rst_valid", 32'(mon.meas_valid), 32'd0);
        check("rst_state", 32'(mon.state_o), 32'd0);
        check("rst_err",   32'(mon.err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic cycle: 20 / 10 / 100 us
        pulse(P_TNI);
        check("s1_emit", 32'(mon.state_o), 32'd1);
        ticks(20);
        pulse(P_TKI);
        check("s1_gap", 32'(mon.state_o), 32'd2);
        ticks(10);
        pulse(P_TNP);
        ticks(100);
        pulse(P_TKP);
        check("s1_idle", 32'(mon.state_o), 32'd0);
        pulse(P_TNC);
        check("s1_vld",  32'(vcnt), 32'd1);
        check("s1_tizl", mon.meas_tizl, 32'd20);
        check("s1_gap",  mon.meas_gap, 32'd10);
        check("s1_tpr",  mon.meas_tpr, 32'd100);
        check("s1_nimp", 32'(mon.n_imp), 32'd1);
        check("s1_err",  32'(mon.err), 32'd0);

        // three emission pulses, last one 4 us wide, no reception
        pulse(P_TNI); ticks(5); pulse(P_TKI); ticks(3);
        pulse(P_TNI); ticks(7); pulse(P_TKI); ticks(2);
        pulse(P_TNI); ticks(4); pulse(P_TKI);
        pulse(P_TNC);
        check("s2_vld",   32'(vcnt), 32'd1);
        check("s2_nimp",  32'(mon.n_imp), 32'd3);
        check("s2_tizl",  mon.meas_tizl, 32'd4);
        check("s2_gap",   mon.meas_gap, 32'd0);
        check("s2_tpr",   mon.meas_tpr, 32'd0);
        check("s2_state", 32'(mon.state_o), 32'd2);

        // reset during EMIT after 7 ticks
        pulse(P_TNI);
        ticks(7);
        check("s7_emit", 32'(mon.state_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("s7_state", 32'(mon.state_o), 32'd0);
        check("s7_tizl",  mon.meas_tizl, 32'd0);
        check("s7_nimp",  32'(mon.n_imp), 32'd0);
        check("s7_err",   32'(mon.err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse(P_TKI);
        check("s7_stray_tki", 32'(mon.err), 32'h84);
        check("s7_state2",    32'(mon.state_o), 32'd0);
        clear_err();
        check("s7_clr", 32'(mon.err), 32'd0);

        // TNI during reception -> overlap
        pulse(P_TNP);
        check("s3_recv", 32'(mon.state_o), 32'd3);
        ticks(50);
        pulse(P_TNI);
        check("s3_err",   32'(mon.err), 32'h81);
        check("s3_state", 32'(mon.state_o), 32'd1);
        clear_err();
        check("s3_clr", 32'(mon.err), 32'd0);
        pulse(P_TKI); pulse(P_TNP); pulse(P_TKP);
        check("s3_idle", 32'(mon.state_o), 32'd0);
        check("s3_err2", 32'(mon.err), 32'd0);

        // stray TKP in IDLE, then start and end in the same clk
        pulse(P_TKP);
        check("s4_err",   32'(mon.err), 32'h88);
        check("s4_state", 32'(mon.state_o), 32'd0);
        clear_err();
        pulse(P_TNI | P_TKI);
        check("s4_sim_state", 32'(mon.state_o), 32'd1);
        check("s4_sim_err",   32'(mon.err), 32'h84);
        clear_err();

        // TNI coinciding with TNC belongs to the new cycle
        pulse(P_TKI);
        pulse(P_TNC | P_TNI);
        check("s5_vld",   32'(vcnt), 32'd1);
        check("s5_nimp",  32'(mon.n_imp), 32'd2);
        check("s5_state", 32'(mon.state_o), 32'd1);
        check("s5_err",   32'(mon.err), 32'd0);
        pulse(P_TKI);
        pulse(P_TNC);
        check("s5_nimp2", 32'(mon.n_imp), 32'd1);
        check("s5_err2",  32'(mon.err), 32'd0);

        // watchdog at 200 ticks, then an empty cycle is published
        ticks(199);
        check("s6_wd_199", 32'(mon.err), 32'd0);
        ticks(1);
        check("s6_wd_200", 32'(mon.err), 32'hA0);
        ticks(50);
        pulse(P_TNC);
        check("s6_vld",  32'(vcnt), 32'd1);
        check("s6_nimp", 32'(mon.n_imp), 32'd0);
        check("s6_err",  32'(mon.err), 32'hE0);
        clear_err();
        check("s6_clr", 32'(mon.err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
